// File: rtl/zx_vram_writer.sv
// ZX Spectrum screen-memory write front end: window filter, write FIFO, border latch.
// Define VRAM_CLEAR_EN to compile in the post-reset screen clear.
module zx_vram_writer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [7:0]  io_data,
  output logic        vram_we,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_din,
  output logic [2:0]  border,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_CLEAR,
    S_RUN
  } state_e;

  state_e state_q, state_d;

  logic [20:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        full, empty;
  logic        in_win, push, pop;
  logic [20:0] head;

  logic        we_q, we_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic [2:0]  border_q;

`ifdef VRAM_CLEAR_EN
  logic [12:0] clr_q, clr_d;
`endif

  logic unused_io;
  assign unused_io = ^{io_addr[15:1], io_data[7:3]};

  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign head  = mem_q[rptr_q[AW-1:0]];

  assign in_win   = (wr_addr >= 16'h4000) && (wr_addr <= 16'h5AFF);
  assign wr_ready = !full && (state_q == S_RUN);
  assign push     = wr_valid && wr_ready && in_win;
  assign pop      = (state_q == S_RUN) && !empty;

  assign vram_we   = we_q;
  assign vram_addr = addr_q;
  assign vram_din  = din_q;
  assign border    = border_q;
  assign busy      = (state_q == S_CLEAR) || !empty;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
`ifdef VRAM_CLEAR_EN
    clr_d   = clr_q;
`endif
    case (state_q)
      S_INIT: begin
`ifdef VRAM_CLEAR_EN
        state_d = S_CLEAR;
        clr_d   = '0;
`else
        state_d = S_RUN;
`endif
      end
      S_CLEAR: begin
`ifdef VRAM_CLEAR_EN
        we_d   = 1'b1;
        addr_d = clr_q;
        din_d  = (clr_q >= 13'h1800) ? 8'h38 : 8'h00;
        clr_d  = clr_q + 13'd1;
        if (clr_q == 13'h1AFF) begin
          state_d = S_RUN;
        end
`else
        state_d = S_RUN;
`endif
      end
      S_RUN: begin
        if (pop) begin
          we_d   = 1'b1;
          addr_d = head[20:8];
          din_d  = head[7:0];
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
`ifdef VRAM_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
`ifdef VRAM_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // 0x4000 is a multiple of 8192, so the offset is just the low 13 bits
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= {wr_addr[12:0], wr_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      border_q <= 3'b000;
    end else if (io_wr && !io_addr[0]) begin
      border_q <= io_data[2:0];
    end
  end

endmodule
